// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for a single-clock data-memory RAM: fixed priority with m1 starvation override,
// or round-robin when DMEM_ARB_RR_EN is defined. Byte-to-word translation, range check, tagged read response.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic              m1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data
);

  logic              w_m0_oor, w_m1_oor;
  logic [ADDR_W-1:0] w_m0_word, w_m1_word;
  logic              w_m1_prio;
  logic              w_m0_gnt, w_m1_gnt, w_any;
  logic              w_we, w_oor;
  logic [ADDR_W-1:0] w_word;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused;

  logic              r_m0_rvalid, r_m1_rvalid;
  logic              r_m0_err, r_m1_err;
  logic              r_rd_oor;

  assign w_m0_oor  = |m0_addr[31:ADDR_W+2];
  assign w_m1_oor  = |m1_addr[31:ADDR_W+2];
  assign w_m0_word = m0_addr[ADDR_W+1:2];
  assign w_m1_word = m1_addr[ADDR_W+1:2];
  // Byte offset is irrelevant for word-only accesses.
  assign w_unused  = ^{m0_addr[1:0], m1_addr[1:0]};

`ifdef DMEM_ARB_RR_EN
  // r_rr_ptr names the master that wins the next conflict.
  logic r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_any) begin
      r_rr_ptr <= w_m0_gnt;
    end
  end

  assign w_m1_prio = r_rr_ptr;
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_m1_starve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m1_starve <= '0;
    end else if (!m1_req || w_m1_gnt) begin
      r_m1_starve <= '0;
    end else if (r_m1_starve != CNT_W'(STARVE_MAX)) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_m1_starve <= r_m1_starve + 1'b1;
    end
  end

  assign w_m1_prio = (r_m1_starve == CNT_W'(STARVE_MAX));
`endif

  // Grants are held off while reset is asserted so every output is quiet during reset.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    w_m0_gnt = 1'b0;
    w_m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        w_m1_gnt = w_m1_prio;
        w_m0_gnt = !w_m1_prio;
      end else begin
        w_m0_gnt = m0_req;
        w_m1_gnt = m1_req;
      end
    end
  end

  assign w_any   = w_m0_gnt | w_m1_gnt;
  assign w_we    = w_m1_gnt ? m1_we     : m0_we;
  assign w_oor   = w_m1_gnt ? w_m1_oor  : w_m0_oor;
  assign w_word  = w_m1_gnt ? w_m1_word : w_m0_word;
  assign w_wdata = w_m1_gnt ? m1_wdata  : m0_wdata;

  assign m0_gnt     = w_m0_gnt;
  assign m1_gnt     = w_m1_gnt;
  assign mem_w_en   = w_any &&  w_we && !w_oor;
  assign mem_r_en   = w_any && !w_we && !w_oor;
  assign mem_w_addr = w_word;
  assign mem_r_addr = w_word;
  assign mem_w_data = w_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m1_err    <= 1'b0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_m0_rvalid <= w_m0_gnt && !m0_we;
      r_m1_rvalid <= w_m1_gnt && !m1_we;
      r_m0_err    <= w_m0_gnt && w_m0_oor;
      r_m1_err    <= w_m1_gnt && w_m1_oor;
      r_rd_oor    <= w_any && !w_we && w_oor;
    end
  end

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_err    = r_m0_err;
  assign m1_err    = r_m1_err;
  // Out-of-range reads return zero instead of whatever the RAM last produced.
  assign rdata = ((r_m0_rvalid || r_m1_rvalid) && !r_rd_oor) ? mem_r_data : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-clock RAM attached.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DATA_W-1:0] rdata, mem_w_data, mem_r_data;
  logic mem_w_en, mem_r_en;
  logic [ADDR_W-1:0] mem_w_addr, mem_r_addr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .rdata(rdata),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
    mem_r_data = '0;
  end

  always @(posedge clk) begin
    if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= ram[mem_r_addr];
  end

  task automatic do_reset();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    m0_req = 0; m1_req = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_w_en, mem_r_en} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_w_en, mem_r_en});
    end
    n_cmp++;
    if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({m0_gnt, mem_w_en, mem_r_en} !== 3'b110) begin
      n_bad++; $display("FAIL wr_ctrl: got gnt/wen/ren %b want 110", {m0_gnt, mem_w_en, mem_r_en});
    end
    n_cmp++;
    if (mem_w_addr !== 9'd4) begin n_bad++; $display("FAIL wr_addr: got %0d want 4", mem_w_addr); end
    n_cmp++;
    if (mem_w_data !== 32'h1234_5678) begin
      n_bad++; $display("FAIL wr_data: got %h want 12345678", mem_w_data);
    end
    @(negedge clk);
    m0_we = 0;
    #1;
    n_cmp++;
    if ({m0_gnt, mem_r_en, mem_w_en} !== 3'b110) begin
      n_bad++; $display("FAIL rd_ctrl: got gnt/ren/wen %b want 110", {m0_gnt, mem_r_en, mem_w_en});
    end
    n_cmp++;
    if (mem_r_addr !== 9'd4) begin n_bad++; $display("FAIL rd_addr: got %0d want 4", mem_r_addr); end
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rsp: got rvalid %b want 0", m0_rvalid); end
    @(negedge clk);
    m0_req = 0;
    #1;
    n_cmp++;
    if ({m0_rvalid, m0_err, m1_rvalid} !== 3'b100) begin
      n_bad++; $display("FAIL rd_rsp: got rvalid/err/m1_rvalid %b want 100", {m0_rvalid, m0_err, m1_rvalid});
    end
    n_cmp++;
    if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data: got %h want 12345678", rdata); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_single_pulse: got %b want 0", m0_rvalid); end
  endtask

`ifndef DMEM_ARB_RR_EN
  task automatic test_starvation();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h20;
      m1_req = 1; m1_we = 0; m1_addr = 32'h24;
      #1;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== ((c == 8) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL starve_gnt c%0d: got m0/m1 %b want %b", c, {m0_gnt, m1_gnt},
                          (c == 8) ? 2'b01 : 2'b10);
      end
      if (c > 0) begin
        n_cmp++;
        if ({m0_rvalid, m1_rvalid} !== ((c == 9) ? 2'b01 : 2'b10)) begin
          n_bad++; $display("FAIL starve_tag c%0d: got m0/m1 rvalid %b want %b", c,
                            {m0_rvalid, m1_rvalid}, (c == 9) ? 2'b01 : 2'b10);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (mem_r_addr !== 9'd9) begin n_bad++; $display("FAIL starve_addr: got %0d want 9", mem_r_addr); end
      end
    end
    @(negedge clk);
    m0_req = 0; m1_req = 0;
  endtask
`else
  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h20;
      m1_req = 1; m1_we = 0; m1_addr = 32'h24;
      #1;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL rr_gnt c%0d: got m0/m1 %b want %b", c, {m0_gnt, m1_gnt},
                          (c % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    @(negedge clk);
    m0_req = 0; m1_req = 0;
  endtask
`endif

  task automatic test_out_of_range();
    @(negedge clk);
    m1_req = 1; m1_we = 0; m1_addr = 32'h800;
    #1;
    n_cmp++;
    if ({m1_gnt, mem_r_en, mem_w_en} !== 3'b100) begin
      n_bad++; $display("FAIL oor_rd_ctrl: got gnt/ren/wen %b want 100", {m1_gnt, mem_r_en, mem_w_en});
    end
    @(negedge clk);
    m1_req = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'hFFFF_FFF0; m0_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({m1_err, m1_rvalid, m0_err, m0_rvalid} !== 4'b1100) begin
      n_bad++; $display("FAIL oor_rd_rsp: got m1err/m1rv/m0err/m0rv %b want 1100",
                        {m1_err, m1_rvalid, m0_err, m0_rvalid});
    end
    n_cmp++;
    if (rdata !== '0) begin n_bad++; $display("FAIL oor_rd_data: got %h want 0", rdata); end
    n_cmp++;
    if ({m0_gnt, mem_w_en} !== 2'b10) begin
      n_bad++; $display("FAIL oor_wr_ctrl: got gnt/wen %b want 10", {m0_gnt, mem_w_en});
    end
    @(negedge clk);
    m0_we = 0; m0_addr = 32'h7FC;
    #1;
    n_cmp++;
    if ({m0_err, m0_rvalid, m1_err} !== 3'b100) begin
      n_bad++; $display("FAIL oor_wr_rsp: got err/rvalid/m1err %b want 100", {m0_err, m0_rvalid, m1_err});
    end
    n_cmp++;
    if ({mem_r_en, mem_r_addr} !== {1'b1, 9'd511}) begin
      n_bad++; $display("FAIL top_word: got ren %b addr %0d want 1 511", mem_r_en, mem_r_addr);
    end
    @(negedge clk);
    m0_req = 0;
    #1;
    n_cmp++;
    if ({m0_rvalid, m0_err} !== 2'b10) begin
      n_bad++; $display("FAIL top_word_rsp: got rvalid/err %b want 10", {m0_rvalid, m0_err});
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_d [3];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m1_req = 1; m1_we = 1; m1_addr = 32'(4 * (i + 1)); m1_wdata = exp_d[i];
      #1;
      n_cmp++;
      if ({m1_gnt, mem_w_en, mem_w_addr} !== {2'b11, 9'(i + 1)}) begin
        n_bad++; $display("FAIL preload w%0d: got gnt %b wen %b addr %0d want 1 1 %0d",
                          i + 1, m1_gnt, mem_w_en, mem_w_addr, i + 1);
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m1_req = 0;
      m0_req = (c < 3); m0_we = 0; m0_addr = 32'(4 * (c + 1));
      #1;
      if (c < 3) begin
        n_cmp++;
        if ({m0_gnt, mem_r_en, mem_r_addr} !== {2'b11, 9'(c + 1)}) begin
          n_bad++; $display("FAIL b2b_issue c%0d: got gnt %b ren %b addr %0d want 1 1 %0d",
                            c, m0_gnt, mem_r_en, mem_r_addr, c + 1);
        end
      end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (m0_rvalid !== 1'b1 || rdata !== exp_d[c-1]) begin
          n_bad++; $display("FAIL b2b_rsp c%0d: got rvalid %b rdata %h want 1 %h", c, m0_rvalid, rdata, exp_d[c-1]);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got rvalid %b want 0", m0_rvalid); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    // A pulse already on the output must vanish the moment reset asserts.
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    @(negedge clk);
    m0_req = 0;
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_rvalid: got %b want 1", m0_rvalid); end
    rst_n = 0;
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0 || rdata !== '0) begin
      n_bad++; $display("FAIL async_clear: got rvalid %b rdata %h want 0 0", m0_rvalid, rdata);
    end
    @(negedge clk);
    rst_n = 1;
    // Grant seen, then reset lands before the edge that would register the response.
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    #1;
    n_cmp++;
    if ({m0_gnt, mem_r_en} !== 2'b11) begin
      n_bad++; $display("FAIL mid_grant: got gnt/ren %b want 11", {m0_gnt, mem_r_en});
    end
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({m0_gnt, mem_r_en, m0_rvalid} !== 3'b000) begin
      n_bad++; $display("FAIL in_rst_quiet: got gnt/ren/rvalid %b want 000", {m0_gnt, mem_r_en, m0_rvalid});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL in_rst_rvalid: got %b want 0", m0_rvalid); end
    @(negedge clk);
    m0_req = 0;
    rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({m0_rvalid, m0_err, m1_rvalid} !== 3'b000) begin
        n_bad++; $display("FAIL post_rst c%0d: got rvalid/err/m1rv %b want 000", c, {m0_rvalid, m0_err, m1_rvalid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
`ifndef DMEM_ARB_RR_EN
    test_starvation();
`else
    test_round_robin();
`endif
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory block RAM (one write port, one read port, both on one clock) between two masters.
- Master 0 is the core load/store unit; master 1 is the debug/program loader.
- Issues at most one access per cycle, translates byte addresses to word addresses, and returns read data with a tagged valid pulse.
- Flags accesses that fall outside the RAM.

Parameters:
- ADDR_W, 9, word-address width of the RAM port (depth = 2^ADDR_W words).
- DATA_W, 32, data width.
- STARVE_MAX, 8, consecutive denied cycles after which a waiting master is forced to win under fixed priority.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_err  out  1  master 0 out-of-range pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_err: same as master 0, for master 1.
- rdata  out  DATA_W  read data shared by both masters; qualified by mX_rvalid.
- mem_w_en  out  1  RAM write-port enable.
- mem_w_addr  out  ADDR_W  RAM write word address.
- mem_w_data  out  DATA_W  RAM write data.
- mem_r_en  out  1  RAM read-port enable.
- mem_r_addr  out  ADDR_W  RAM read word address.
- mem_r_data  in  DATA_W  RAM read data, valid 1 cycle after mem_r_en.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset values: all gnt/rvalid/err outputs 0, rdata 0, mem_* enables 0, starvation counters 0, RR pointer = master 0.
- Arbitration is combinational within the cycle. A winner is chosen among asserted reqs; the winner's gnt = 1 in the same cycle; the loser's gnt = 0 and it must hold req/addr/we/wdata stable until granted.
- Fixed priority (default): m0 wins a conflict, except as follows.
  - When m1 has been denied while requesting for STARVE_MAX consecutive cycles, m1 wins the next conflict.
  - The m1 counter clears when m1 is granted or drops req.
  - The counter saturates at STARVE_MAX.
- Address check: word = addr[ADDR_W+1:2]. The access is out of range if addr[31:ADDR_W+2] != 0. Addr[1:0] is ignored (word access only).
- Granted in-range write: mem_w_en = 1, mem_w_addr = word, mem_w_data = wdata, same cycle. No response pulse.
- Granted in-range read: mem_r_en = 1, mem_r_addr = word, same cycle. A registered tag records the winner.
  - Next cycle: winner's rvalid = 1 for exactly 1 cycle; rdata = mem_r_data.
- Granted out-of-range access: gnt = 1, no mem enable.
  - Next cycle: that master's err = 1 for 1 cycle.
  - For reads, rvalid = 1 also, with rdata = 0.
- Back-to-back reads allowed: one read per cycle, responses in issue order, latency exactly 1.
- Same-cycle read and write from different masters is not allowed: only one grant per cycle, even though the RAM has two ports. This keeps read-after-write ordering trivial.
- A write and a later read to the same word return the new data.
- Reset mid-read: the pending rvalid is suppressed; no pulse after rst_n deasserts.
- No req asserted: all enables 0 and the RR pointer is unchanged.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a conflict, the master not granted most recently wins.
  - The pointer updates only on a grant.
  - The starvation counter and STARVE_MAX logic are removed.
- Not defined: fixed priority with starvation override as described in Behaviour.

Test Plan:
- Reset, then m0 writes 0x12345678 to byte addr 0x10, then reads 0x10 -> mem_w_addr = 4 on the write; next cycle m0_rvalid = 1, rdata = 0x12345678.
- m0 and m1 both hold read req for 12 cycles (fixed priority, STARVE_MAX = 8) -> m0 granted cycles 0-7, m1 granted cycle 8, m0 granted again at cycle 9.
- Same conflict with DMEM_ARB_RR_EN defined -> grants alternate m0, m1, m0, m1 every cycle.
- m1 reads byte addr 0x800 (ADDR_W = 9) -> m1_gnt = 1, mem_r_en = 0; next cycle m1_err = 1, m1_rvalid = 1, rdata = 0.
- m0 issues reads on 3 consecutive cycles to words 1, 2, 3 preloaded 0xA, 0xB, 0xC -> m0_rvalid high for 3 consecutive cycles with rdata 0xA, 0xB, 0xC in order.
- Assert rst_n low in the cycle after an m0 read grant -> m0_rvalid stays 0 during and after reset; all outputs return to reset values immediately (asynchronously).
